bird_physics: RTL and testbench
===============================

Name: bird_physics

Overview:
- Per-bird motion engine that produces the raw bird position and sprite-animation state consumed by the bird selection stage ahead of the display renderer.
- Integrates gravity and flap impulses once per video frame.
- Holds the start position in menu and ready states, and freezes the bird on game over.
- Instantiated twice (yellow and blue bird) with different H_POS values.

Parameters:
H_POS, 320, fixed horizontal position driven on bird_h
START_V, 240, vertical position held in states 3'b000/3'b001
GROUND_V, 440, lowest legal bird_v; reaching it raises hit_ground
GRAVITY, 1, velocity increment per frame (pixels/frame)
FLAP_IMPULSE, 8, upward velocity magnitude loaded on a flap
VMAX, 10, terminal downward velocity (pixels/frame)
ANIM_DIV, 6, frames per animation step
DEBOUNCE_CYCLES, 500000, flap stable-time in clk cycles (only with FLAP_DEBOUNCE_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
state  in  3  game state: 000 menu, 001 ready, 010 play, 011..111 game over
frame_tick  in  1  one-clk pulse per video frame (end of active video)
flap  in  1  raw flap button level, active high
bird_h  out  11  bird horizontal position
bird_v  out  11  bird vertical position
bird_anim  out  2  sprite state: 0/1/2 wing frames, 3 dead
hit_ground  out  1  sticky flag: bird reached GROUND_V during play
vel  out  6  signed current velocity, two's complement, positive = down (debug/score use)

Behaviour:
- Reset (async, rst_n=0): bird_h=H_POS, bird_v=START_V, vel=0, bird_anim=0, hit_ground=0, flap_pending=0, anim_cnt=0, flap synchroniser cleared. Outputs take these values immediately on reset assertion.
- Flap input path:
  - Two-flop synchroniser, then rising-edge detect.
  - Each edge sets flap_pending, regardless of state.
  - flap_pending is cleared on every frame_tick.
  - Multiple edges within one frame count as one flap.
- Menu/ready (state 000 or 001), evaluated every clk (not gated by frame_tick):
  - bird_v=START_V, vel=0, hit_ground=0, bird_anim=0, anim_cnt=0.
  - Pending flaps are discarded at the next frame_tick.
- Play (010), all updates occur only on the frame_tick cycle; registers are stable otherwise:
  - next_v = bird_v + vel, computed at 12-bit signed width.
  - If next_v >= GROUND_V: bird_v=GROUND_V, vel=0, hit_ground=1.
  - Else if next_v < 0: bird_v=0, vel=0 (ceiling clamp). The flap rule below still applies on the same tick.
  - Else: bird_v=next_v.
  - Velocity: if flap_pending (including an edge arriving on the same cycle as frame_tick), vel=-FLAP_IMPULSE. Otherwise vel=min(vel+GRAVITY, VMAX).
  - Position uses the pre-update vel, giving one frame of latency from flap to upward motion.
  - While hit_ground=1: position, vel and animation freeze until state leaves play. The upstream FSM is expected to move to game over.
  - Animation: anim_cnt counts frame_ticks 0..ANIM_DIV-1. On wrap, bird_anim steps 0->1->2->0; bird_anim never reaches 3 in play.
- Game over (011..111): bird_v, vel and hit_ground hold; bird_anim=3; flaps ignored.
- State change mid-frame: takes effect on the next clk.
- Return from game over to menu re-initialises as above.
- bird_h is constant H_POS in all states.
- Widths: vel is 6-bit signed, so FLAP_IMPULSE and VMAX must be <= 31. The sum is saturated and never wraps.

Optional Feature:
- Macro FLAP_DEBOUNCE_EN.
- When defined: the synchronised flap must remain at a new level for DEBOUNCE_CYCLES consecutive clk before the debounced level changes. The edge detector operates on the debounced level. Added flap latency is DEBOUNCE_CYCLES clk.
- When undefined: the edge detector operates directly on the synchronised input and no counter is instantiated.

Test Plan:
- Reset release in state 000 with no flap -> bird_h=320, bird_v=240, vel=0, bird_anim=0, hit_ground=0; values persist through 10 frame_ticks.
- Enter 010, no flap, vel starts at 0 -> after ticks 1..4, bird_v=240,241,243,246 and vel=1,2,3,4. vel saturates at 10 and never exceeds it.
- In 010 with bird_v=300 and vel=5, pulse flap 3 times between ticks -> next tick: bird_v=305, vel=-8. Following tick: bird_v=297, vel=-7.
- Fall from bird_v=435 with vel=10 -> bird_v=440, hit_ground=1, vel=0. Further ticks leave the values unchanged.
- Flap repeatedly from bird_v=5 -> bird_v clamps to 0 and never wraps to 2047.
- Play with ANIM_DIV=6 over 18 ticks -> bird_anim sequence 0,1,2,0. Set state=011 -> bird_anim=3 on the next clk. Assert rst_n=0 mid-play -> all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/bird_physics_if.sv
// Bird motion engine bus: game-state/frame/flap inputs and the bird's
// position, animation and velocity outputs.
interface bird_physics_if;
    logic [2:0]        state;
    logic              frame_tick;
    logic              flap;
    logic [10:0]       bird_h;
    logic [10:0]       bird_v;
    logic [1:0]        bird_anim;
    logic              hit_ground;
    logic signed [5:0] vel;

    // Game controller / bench side: drives state, frame and button.
    modport master (
        output state, frame_tick, flap,
        input  bird_h, bird_v, bird_anim, hit_ground, vel
    );

    // Physics engine side.
    modport slave (
        input  state, frame_tick, flap,
        output bird_h, bird_v, bird_anim, hit_ground, vel
    );
endinterface

// File: rtl/bird_physics.sv
// Per-bird motion engine: integrates gravity and flap impulses once per
// video frame, clamps at ceiling and ground, and steps the wing animation.
// Optional macro FLAP_DEBOUNCE_EN inserts a stable-time debouncer between
// the flap synchroniser and the edge detector.
module bird_physics #(
    parameter int H_POS           = 320,
    parameter int START_V         = 240,
    parameter int GROUND_V        = 440,
    parameter int GRAVITY         = 1,
    parameter int FLAP_IMPULSE    = 8,
    parameter int VMAX            = 10,
    parameter int ANIM_DIV        = 6,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic         clk,
    input  logic         rst_n,
    bird_physics_if.slave bus
);

    localparam int                 AW         = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [10:0]        START_V_C  = 11'(START_V);
    localparam logic [10:0]        GROUND_V_U = 11'(GROUND_V);
    localparam logic signed [11:0] GROUND_V_C = 12'(GROUND_V);
    localparam logic signed [5:0]  FLAP_VEL_C = 6'(-FLAP_IMPULSE);
    localparam logic signed [5:0]  VMAX_C     = 6'(VMAX);
    localparam logic signed [7:0]  VMAX_W     = 8'(VMAX);
    localparam logic signed [7:0]  VMIN_W     = -8'sd32;
    localparam logic signed [7:0]  GRAV_C     = 8'(GRAVITY);
    localparam logic [AW-1:0]      ANIM_LAST  = AW'(ANIM_DIV - 1);

    // Velocity register is 6-bit signed; larger magnitudes cannot be held.
    if (VMAX > 31 || FLAP_IMPULSE > 31) begin : g_bad_vel
        $error("bird_physics: VMAX and FLAP_IMPULSE must be <= 31");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
        $error("bird_physics: DEBOUNCE_CYCLES must be >= 1");
    end

    // Saturate a widened velocity sum into the 6-bit signed range, capped at VMAX.
    function automatic logic signed [5:0] sat_vel(input logic signed [7:0] x);
        if (x > VMAX_W) begin
            sat_vel = VMAX_C;
        end else if (x < VMIN_W) begin
            sat_vel = 6'sb100000;
        end else begin
            sat_vel = x[5:0];
        end
    endfunction

    logic              flap_s1_q, flap_s1_d;
    logic              flap_s2_q, flap_s2_d;
    logic              flap_lvl;
    logic              flap_prev_q, flap_prev_d;
    logic              flap_pending_q, flap_pending_d;
    logic              flap_edge;
    logic              flap_now;
    logic [10:0]       bird_v_q, bird_v_d;
    logic signed [5:0] vel_q, vel_d;
    logic [1:0]        anim_q, anim_d;
    logic [AW-1:0]     anim_cnt_q, anim_cnt_d;
    logic              hit_q, hit_d;
    logic signed [11:0] next_v;
    logic signed [7:0]  vel_sum;

`ifdef FLAP_DEBOUNCE_EN
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

    logic           db_lvl_q, db_lvl_d;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;

    // Accept a new flap level only after it has been stable DEBOUNCE_CYCLES clocks.
    always_comb begin
        db_lvl_d = db_lvl_q;
        db_cnt_d = '0;
        if (flap_s2_q != db_lvl_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_lvl_d = flap_s2_q;
            end else begin
                db_cnt_d = db_cnt_q + DBW'(1);
            end
        end
    end

    // Debouncer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_lvl_q <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            db_lvl_q <= db_lvl_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign flap_lvl = db_lvl_q;
`else
    assign flap_lvl = flap_s2_q;
`endif

    // Flap capture plus per-state motion update (play updates only on frame_tick).
    always_comb begin
        flap_s1_d      = bus.flap;
        flap_s2_d      = flap_s1_q;
        flap_prev_d    = flap_lvl;
        flap_edge      = flap_lvl & ~flap_prev_q;
        // An edge landing on the tick cycle still counts for that frame.
        flap_now       = flap_pending_q | flap_edge;
        flap_pending_d = bus.frame_tick ? 1'b0 : flap_now;

        bird_v_d   = bird_v_q;
        vel_d      = vel_q;
        anim_d     = anim_q;
        anim_cnt_d = anim_cnt_q;
        hit_d      = hit_q;

        next_v  = $signed({1'b0, bird_v_q}) + {{6{vel_q[5]}}, vel_q};
        vel_sum = {{2{vel_q[5]}}, vel_q} + GRAV_C;

        case (bus.state)
            3'b000, 3'b001: begin
                bird_v_d   = START_V_C;
                vel_d      = '0;
                anim_d     = 2'd0;
                anim_cnt_d = '0;
                hit_d      = 1'b0;
            end
            3'b010: begin
                if (bus.frame_tick && !hit_q) begin
                    // Position moves with the pre-update velocity.
                    if (next_v >= GROUND_V_C) begin
                        bird_v_d = GROUND_V_U;
                        vel_d    = '0;
                        hit_d    = 1'b1;
                    end else if (next_v < 12'sd0) begin
                        bird_v_d = '0;
                        vel_d    = flap_now ? FLAP_VEL_C : 6'sd0;
                    end else begin
                        bird_v_d = next_v[10:0];
                        vel_d    = flap_now ? FLAP_VEL_C : sat_vel(vel_sum);
                    end

                    if (anim_cnt_q == ANIM_LAST) begin
                        anim_cnt_d = '0;
                        anim_d     = (anim_q == 2'd2) ? 2'd0 : anim_q + 2'd1;
                    end else begin
                        anim_cnt_d = anim_cnt_q + AW'(1);
                    end
                end
            end
            default: begin
                anim_d = 2'd3;
            end
        endcase
    end

    // State registers; outputs drop to reset values as soon as rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flap_s1_q      <= 1'b0;
            flap_s2_q      <= 1'b0;
            flap_prev_q    <= 1'b0;
            flap_pending_q <= 1'b0;
            bird_v_q       <= START_V_C;
            vel_q          <= '0;
            anim_q         <= 2'd0;
            anim_cnt_q     <= '0;
            hit_q          <= 1'b0;
        end else begin
            flap_s1_q      <= flap_s1_d;
            flap_s2_q      <= flap_s2_d;
            flap_prev_q    <= flap_prev_d;
            flap_pending_q <= flap_pending_d;
            bird_v_q       <= bird_v_d;
            vel_q          <= vel_d;
            anim_q         <= anim_d;
            anim_cnt_q     <= anim_cnt_d;
            hit_q          <= hit_d;
        end
    end

    assign bus.bird_h     = 11'(H_POS);
    assign bus.bird_v     = bird_v_q;
    assign bus.vel        = vel_q;
    assign bus.bird_anim  = anim_q;
    assign bus.hit_ground = hit_q;

endmodule

// File: tb/tb_bird_physics.sv
// Bench for bird_physics: table of per-frame vectors with hand-computed
// expectations, plus ceiling, ground, game-over and async-reset sequences.
module tb_bird_physics;

    typedef struct {
        logic [2:0] st;
        int         nf;
        int         v;
        int         vel;
        int         anim;
        int         hit;
    } vec_t;

    typedef struct {
        int v;
        int vel;
        int anim;
        int hit;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    vec_t tbl[$];
    exp_t exp_q[$];

    bird_physics_if bus ();

    bird_physics dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic add(input logic [2:0] st, input int nf, input int v,
                       input int vel, input int anim, input int hit);
        vec_t r;
        r.st = st; r.nf = nf; r.v = v; r.vel = vel; r.anim = anim; r.hit = hit;
        tbl.push_back(r);
    endtask

    task automatic push_exp(input int v, input int vel, input int anim, input int hit);
        exp_t e;
        e.v = v; e.vel = vel; e.anim = anim; e.hit = hit;
        exp_q.push_back(e);
    endtask

    task automatic cmp(input string nm, input string f, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s %s: got %0d, required %0d", nm, f, act, req);
        end
    endtask

    task automatic check_out(input string nm);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s scoreboard: got empty queue, required an entry", nm);
            return;
        end
        e = exp_q.pop_front();
        cmp(nm, "bird_h",     int'(bus.bird_h),        320);
        cmp(nm, "bird_v",     int'(bus.bird_v),        e.v);
        cmp(nm, "vel",        int'($signed(bus.vel)),  e.vel);
        cmp(nm, "bird_anim",  int'(bus.bird_anim),     e.anim);
        cmp(nm, "hit_ground", int'(bus.hit_ground),    e.hit);
    endtask

    // Enter at a negedge: set state, pulse flap nf times, then one frame_tick.
    // Returns at the negedge following the tick's active edge.
    task automatic apply(input logic [2:0] st, input int nf);
        bus.state = st;
        for (int k = 0; k < nf; k++) begin
            bus.flap = 1'b1;
            repeat (2) @(negedge clk);
            bus.flap = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
    endtask

    initial begin
        int mv, mvel, mt, mh, nv;
        n_tests = 0;
        n_fail  = 0;
        rst_n          = 1'b0;
        bus.state      = 3'b000;
        bus.frame_tick = 1'b0;
        bus.flap       = 1'b0;

        // Menu: 10 frames hold the start pose; the last one has a flap that
        // must be discarded before play starts.
        for (int i = 0; i < 9; i++) add(3'b000, 0, 240, 0, 0, 0);
        add(3'b000, 1, 240, 0, 0, 0);
        // Play from rest: gravity accumulation up to VMAX.
        add(3'b010, 0, 240,  1, 0, 0);
        add(3'b010, 0, 241,  2, 0, 0);
        add(3'b010, 0, 243,  3, 0, 0);
        add(3'b010, 0, 246,  4, 0, 0);
        add(3'b010, 0, 250,  5, 0, 0);
        add(3'b010, 0, 255,  6, 1, 0);
        add(3'b010, 0, 261,  7, 1, 0);
        add(3'b010, 0, 268,  8, 1, 0);
        add(3'b010, 0, 276,  9, 1, 0);
        add(3'b010, 0, 285, 10, 1, 0);
        add(3'b010, 0, 295, 10, 1, 0);
        // Three flaps in one frame act as one; motion lags by one frame.
        add(3'b010, 3, 305, -8, 2, 0);
        add(3'b010, 0, 297, -7, 2, 0);
        add(3'b010, 0, 290, -6, 2, 0);
        add(3'b010, 0, 284, -5, 2, 0);
        add(3'b010, 0, 279, -4, 2, 0);
        add(3'b010, 0, 275, -3, 2, 0);
        add(3'b010, 0, 272, -2, 0, 0);

        repeat (3) @(negedge clk);
        push_exp(240, 0, 0, 0);
        check_out("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            push_exp(tbl[i].v, tbl[i].vel, tbl[i].anim, tbl[i].hit);
            apply(tbl[i].st, tbl[i].nf);
            check_out($sformatf("vec%0d", i));
        end

        // Flap every frame until the ceiling clamp holds the bird at 0.
        mv = 272; mvel = -2; mt = 18;
        for (int i = 0; i < 40; i++) begin
            mv   = (mv + mvel < 0) ? 0 : mv + mvel;
            mvel = -8;
            mt++;
            push_exp(mv, mvel, (mt / 6) % 3, 0);
            apply(3'b010, 1);
            check_out($sformatf("ceil%0d", i));
        end

        push_exp(240, 0, 0, 0);
        apply(3'b000, 0);
        check_out("menu_reinit");

        // Free fall from the start position into the ground, then frozen.
        mv = 240; mvel = 0; mh = 0; mt = 0;
        for (int i = 1; i <= 30; i++) begin
            if (mh == 0) begin
                nv = mv + mvel;
                mt++;
                if (nv >= 440) begin
                    mv = 440; mvel = 0; mh = 1;
                end else begin
                    mv   = nv;
                    mvel = (mvel + 1 > 10) ? 10 : mvel + 1;
                end
            end
            push_exp(mv, mvel, (mt / 6) % 3, mh);
            apply(3'b010, 0);
            check_out($sformatf("fall%0d", i));
            if (i == 25) begin
                cmp("fall_pre_ground", "bird_v", int'(bus.bird_v), 435);
                cmp("fall_pre_ground", "vel", int'($signed(bus.vel)), 10);
            end
        end

        // Game over: dead sprite on the next clock, everything else holds.
        bus.state = 3'b011;
        @(negedge clk);
        push_exp(440, 0, 3, 1);
        check_out("gameover");
        push_exp(440, 0, 3, 1);
        apply(3'b111, 1);
        check_out("gameover_hold");

        push_exp(240, 0, 0, 0);
        apply(3'b000, 0);
        check_out("gameover_to_menu");

        // Asynchronous reset in the middle of play.
        push_exp(240, 1, 0, 0);
        apply(3'b010, 0);
        check_out("replay1");
        push_exp(241, 2, 0, 0);
        apply(3'b010, 0);
        check_out("replay2");
        #2;
        rst_n = 1'b0;
        #1;
        push_exp(240, 0, 0, 0);
        check_out("async_reset");
        @(negedge clk);
        rst_n = 1'b1;

        cmp("scoreboard", "leftover", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
